cache_read_controller: RTL and testbench

- Direct-mapped, read-only cache controller that sits between the CPU fetch/load path and the 4-word-wide block RAM.
- It is the requesting side of the RAM interface. It drives a block-aligned 15-bit word address and captures the four returned words (Data0..Data3) as one cache line.
- It returns the single requested 32-bit word to the CPU through a request/ready handshake.
- Main memory is modelled with a fixed access latency of MEM_LATENCY cycles.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_line_store.sv | 41 ++++
 rtl/cache_read_controller.sv | 155 +++++++++++++++
 tb/tb_cache_read_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address-field helpers for the direct-mapped read cache.
package cache_pkg;

    localparam int ADDR_WIDTH  = 15;
    localparam int WORD_WIDTH  = 32;
    localparam int INDEX_BITS  = 10;
    localparam int OFFSET_BITS = 2;
    localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int LINE_WORDS  = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] line_t;

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFSET_BITS-1:0];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for the cache: combinational read by index, synchronous whole-line write.
module cache_line_store
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic                  we,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  line_t                 wr_line,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output line_t                 rd_line
);

    logic [LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0] tag_mem_r  [LINES];
    line_t               line_mem_r [LINES];

    assign rd_valid = valid_r[index];
    assign rd_tag   = tag_mem_r[index];
    assign rd_line  = line_mem_r[index];

    // Valid bits: cleared by reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {LINES{1'b0}};
        end else if (we) begin
            valid_r[index] <= 1'b1;
        end
    end

    // Tag and data storage is never reset; a fill aborted by reset must not land.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_mem_r[index]  <= wr_tag;
            line_mem_r[index] <= wr_line;
        end
    end

endmodule

// File: rtl/cache_read_controller.sv
// Direct-mapped read-only cache controller with a fixed-latency 4-word block RAM behind it.
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_read_controller
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [WORD_WIDTH-1:0] cpu_data,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_data0,
    input  logic [WORD_WIDTH-1:0] mem_data1,
    input  logic [WORD_WIDTH-1:0] mem_data2,
    input  logic [WORD_WIDTH-1:0] mem_data3
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [WORD_WIDTH-1:0] cpu_data_r, cpu_data_s;
    logic                  ready_r, ready_s;
    logic                  hit_r, hit_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic                  line_we_s;
    logic                  rd_valid_s;
    logic [TAG_BITS-1:0]   rd_tag_s;
    line_t                 rd_line_s;
    line_t                 mem_line_s;

    assign mem_line_s = {mem_data3, mem_data2, mem_data1, mem_data0};

    cache_line_store u_store (
        .clk      (clk),
        .rst      (rst),
        .index    (addr_index(addr_r)),
        .we       (line_we_s),
        .wr_tag   (addr_tag(addr_r)),
        .wr_line  (mem_line_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_line  (rd_line_s)
    );

    // Next-state and next-output logic; ready is a single-cycle pulse on entry to DONE.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        addr_s     = addr_r;
        cpu_data_s = cpu_data_r;
        ready_s    = 1'b0;
        hit_s      = hit_r;
        mem_addr_s = mem_addr_r;
        line_we_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    addr_s  = cpu_addr;
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (rd_valid_s && (rd_tag_s == addr_tag(addr_r))) begin
                    cpu_data_s = rd_line_s[addr_offset(addr_r)];
                    hit_s      = 1'b1;
                    ready_s    = 1'b1;
                    state_s    = DONE;
                end else begin
                    mem_addr_s = {addr_tag(addr_r), addr_index(addr_r), {OFFSET_BITS{1'b0}}};
                    cnt_s      = CNT_W'(MEM_LATENCY - 1);
                    state_s    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    line_we_s  = 1'b1;
                    cpu_data_s = mem_line_s[addr_offset(addr_r)];
                    hit_s      = 1'b0;
                    ready_s    = 1'b1;
                    state_s    = DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= {ADDR_WIDTH{1'b0}};
            cpu_data_r <= {WORD_WIDTH{1'b0}};
            ready_r    <= 1'b0;
            hit_r      <= 1'b0;
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            addr_r     <= addr_s;
            cpu_data_r <= cpu_data_s;
            ready_r    <= ready_s;
            hit_r      <= hit_s;
            mem_addr_r <= mem_addr_s;
        end
    end

    assign cpu_data  = cpu_data_r;
    assign cpu_ready = ready_r;
    assign cpu_hit   = hit_r;
    assign mem_addr  = mem_addr_r;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_r, miss_cnt_r;

    // Saturating transaction counters, stepped once per completed request.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else if (state_r == DONE) begin
            if (hit_r && (hit_cnt_r != 16'hFFFF)) begin
                hit_cnt_r <= hit_cnt_r + 16'h0001;
            end else if (!hit_r && (miss_cnt_r != 16'hFFFF)) begin
                miss_cnt_r <= miss_cnt_r + 16'h0001;
            end
        end
    end

    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;
`endif

endmodule

// File: tb/tb_cache_read_controller.sv
// Directed self-checking bench for cache_read_controller; RAM model returns 32'hA000_0000 | addr.
module tb_cache_read_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        cpu_hit;
    logic [14:0] mem_addr;
    logic [31:0] mem_data0, mem_data1, mem_data2, mem_data3;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mem_data0 = 32'hA000_0000 | {17'd0, mem_addr};
    assign mem_data1 = 32'hA000_0000 | {17'd0, mem_addr + 15'd1};
    assign mem_data2 = 32'hA000_0000 | {17'd0, mem_addr + 15'd2};
    assign mem_data3 = 32'hA000_0000 | {17'd0, mem_addr + 15'd3};

    cache_read_controller #(.MEM_LATENCY(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .mem_addr  (mem_addr),
        .mem_data0 (mem_data0),
        .mem_data1 (mem_data1),
        .mem_data2 (mem_data2),
        .mem_data3 (mem_data3)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // Drive one request, scramble cpu_addr after it is sampled, report edges-to-ready and outputs.
    task automatic run_req(input logic [14:0] a, output int lat, output logic [31:0] d,
                           output logic h, output logic [14:0] ma, output logic pulse_ok);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        lat      = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) cpu_addr = ~a;
            if (cpu_ready) break;
        end
        d       = cpu_data;
        h       = cpu_hit;
        ma      = mem_addr;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        pulse_ok = !cpu_ready;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (cpu_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want %h", cpu_data, 32'h0); end
        n_chk++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
        n_chk++; if (cpu_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", cpu_hit); end
        n_chk++; if (mem_addr !== 15'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, 15'h0); end
    endtask

    task automatic test_cold_miss();
        int lat; logic [31:0] d; logic h; logic [14:0] ma; logic p;
        run_req(15'h0012, lat, d, h, ma, p);
        n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL cold_lat: got %0d want 6", lat); end
        n_chk++; if (d !== 32'hA000_0012) begin n_fail++; $display("FAIL cold_data: got %h want A0000012", d); end
        n_chk++; if (h !== 1'b0) begin n_fail++; $display("FAIL cold_hit: got %b want 0", h); end
        n_chk++; if (ma !== 15'h0010) begin n_fail++; $display("FAIL cold_mem_addr: got %h want 0010", ma); end
        n_chk++; if (p !== 1'b1) begin n_fail++; $display("FAIL cold_pulse: ready still %b want 0", !p); end
    endtask

    task automatic test_hit();
        int lat; logic [31:0] d; logic h; logic [14:0] ma; logic p;
        run_req(15'h0013, lat, d, h, ma, p);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL hit_lat: got %0d want 2", lat); end
        n_chk++; if (d !== 32'hA000_0013) begin n_fail++; $display("FAIL hit_data: got %h want A0000013", d); end
        n_chk++; if (h !== 1'b1) begin n_fail++; $display("FAIL hit_flag: got %b want 1", h); end
        n_chk++; if (ma !== 15'h0010) begin n_fail++; $display("FAIL hit_mem_addr: got %h want 0010", ma); end
        n_chk++; if (p !== 1'b1) begin n_fail++; $display("FAIL hit_pulse: ready still %b want 0", !p); end
    endtask

    task automatic test_conflict();
        int lat; logic [31:0] d; logic h; logic [14:0] ma; logic p;
        run_req(15'h1012, lat, d, h, ma, p);
        n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL conf1_lat: got %0d want 6", lat); end
        n_chk++; if (d !== 32'hA000_1012) begin n_fail++; $display("FAIL conf1_data: got %h want A0001012", d); end
        n_chk++; if (h !== 1'b0) begin n_fail++; $display("FAIL conf1_hit: got %b want 0", h); end
        n_chk++; if (ma !== 15'h1010) begin n_fail++; $display("FAIL conf1_mem_addr: got %h want 1010", ma); end
        run_req(15'h0012, lat, d, h, ma, p);
        n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL conf2_lat: got %0d want 6", lat); end
        n_chk++; if (d !== 32'hA000_0012) begin n_fail++; $display("FAIL conf2_data: got %h want A0000012", d); end
        n_chk++; if (h !== 1'b0) begin n_fail++; $display("FAIL conf2_hit: got %b want 0", h); end
        n_chk++; if (ma !== 15'h0010) begin n_fail++; $display("FAIL conf2_mem_addr: got %h want 0010", ma); end
    endtask

    task automatic test_top_addr();
        int lat; logic [31:0] d; logic h; logic [14:0] ma; logic p;
        run_req(15'h7FFF, lat, d, h, ma, p);
        n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL top_lat: got %0d want 6", lat); end
        n_chk++; if (d !== 32'hA000_7FFF) begin n_fail++; $display("FAIL top_data: got %h want A0007FFF", d); end
        n_chk++; if (ma !== 15'h7FFC) begin n_fail++; $display("FAIL top_mem_addr: got %h want 7FFC", ma); end
        run_req(15'h7FFC, lat, d, h, ma, p);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL top_hit_lat: got %0d want 2", lat); end
        n_chk++; if (d !== 32'hA000_7FFC) begin n_fail++; $display("FAIL top_hit_data: got %h want A0007FFC", d); end
        n_chk++; if (h !== 1'b1) begin n_fail++; $display("FAIL top_hit_flag: got %b want 1", h); end
    endtask

    task automatic test_reset_mid_fill();
        int lat; logic [31:0] d; logic h; logic [14:0] ma; logic p;
        logic seen_ready;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 15'h2012;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (cpu_data !== 32'h0) begin n_fail++; $display("FAIL abort_data: got %h want 0", cpu_data); end
        n_chk++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", cpu_ready); end
        n_chk++; if (mem_addr !== 15'h0) begin n_fail++; $display("FAIL abort_mem_addr: got %h want 0", mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        seen_ready = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (cpu_ready) seen_ready = 1'b1;
        end
        n_chk++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b want 0", seen_ready); end
        run_req(15'h0012, lat, d, h, ma, p);
        n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL after_abort_lat: got %0d want 6", lat); end
        n_chk++; if (h !== 1'b0) begin n_fail++; $display("FAIL after_abort_hit: got %b want 0", h); end
        n_chk++; if (d !== 32'hA000_0012) begin n_fail++; $display("FAIL after_abort_data: got %h want A0000012", d); end
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_reset();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 15'h0020;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); lat++; #1;
            if (cpu_ready) break;
        end
        n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL b2b_miss_lat: got %0d want 6", lat); end
        n_chk++; if (cpu_data !== 32'hA000_0020) begin n_fail++; $display("FAIL b2b_miss_data: got %h want A0000020", cpu_data); end
        cpu_addr = 15'h0021;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); lat++; #1;
            if (cpu_ready) break;
        end
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_hit_gap: got %0d want 3", lat); end
        n_chk++; if (cpu_data !== 32'hA000_0021) begin n_fail++; $display("FAIL b2b_hit_data: got %h want A0000021", cpu_data); end
        n_chk++; if (cpu_hit !== 1'b1) begin n_fail++; $display("FAIL b2b_hit_flag: got %b want 1", cpu_hit); end
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
`ifdef CACHE_STATS_EN
        n_chk++; if (hit_count !== 16'd1) begin n_fail++; $display("FAIL b2b_hit_count: got %0d want 1", hit_count); end
        n_chk++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL b2b_miss_count: got %0d want 1", miss_count); end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = 15'h0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_top_addr();
        test_reset_mid_fill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
